// File: rtl/lives_ctrl_pkg.sv
// lives_ctrl_pkg: shared state encoding, default sizing and
// the saturating lives increment used by lives_ctrl.
package lives_ctrl_pkg;

  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,
    LS_PLAY   = 2'd1,
    LS_INVULN = 2'd2,
    LS_OVER   = 2'd3
  } ls_state_t;

  localparam int DEF_START_LIVES   = 3;
  localparam int DEF_MAX_LIVES     = 3;
  localparam int DEF_INVULN_FRAMES = 120;
  localparam int DEF_BLINK_FRAMES  = 8;

  // 4-bit sum so 7+1 saturates instead of wrapping
  function automatic logic [2:0] sat_inc(
    input logic [2:0] a,
    input logic       inc,
    input logic [2:0] cap
  );
    logic [3:0] s;
    s = {1'b0, a} + {3'b000, inc};
    return (s > {1'b0, cap}) ? cap : s[2:0];
  endfunction

endpackage

// File: rtl/lives_ctrl_if.sv
// lives_ctrl_if: VGA position, game events and HUD/ship flags
// exchanged between the game logic and lives_ctrl.
interface lives_ctrl_if;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       start;
  logic       hit;
  logic       bonus;
  logic [2:0] me_lifes;
  logic       invuln;
  logic       blink;
  logic       game_over;

  modport master (
    output h_cnt, v_cnt, start, hit, bonus,
    input  me_lifes, invuln, blink, game_over
  );

  modport slave (
    input  h_cnt, v_cnt, start, hit, bonus,
    output me_lifes, invuln, blink, game_over
  );
endinterface

// File: rtl/lives_frame_timer.sv
// lives_frame_timer: loadable down-counter that steps once per
// enabled frame tick and holds at zero.
module lives_frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/lives_ctrl.sv
// lives_ctrl: player lives FSM with frame-synchronous HUD value.
// Define LIVES_BONUS_EN to let the bonus input add lives.
module lives_ctrl
  import lives_ctrl_pkg::*;
#(
  parameter int START_LIVES   = DEF_START_LIVES,
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
  input logic         clk_25MHz,
  input logic         rst,
  lives_ctrl_if.slave bus
);

  ls_state_t  state;
  ls_state_t  state_nx;
  logic [2:0] lives;
  logic [2:0] lives_nx;
  logic [2:0] me_lifes;
  logic [2:0] me_nx;
  logic [2:0] sat;
  logic [2:0] nl;
  logic       blink;
  logic       blink_nx;
  logic       invuln;
  logic       game_over;
  logic       tick;
  logic       bonus_eff;
  logic       inv_load;
  logic       inv_dec;
  logic       blk_load;
  logic       blk_dec;
  logic [7:0] inv_cnt;
  logic [3:0] blk_cnt;

  assign tick = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);

`ifdef LIVES_BONUS_EN
  assign bonus_eff = bus.bonus;
`else
  assign bonus_eff = 1'b0;
`endif

  assign sat = sat_inc(lives, bonus_eff, 3'(MAX_LIVES));
  assign nl  = sat - 3'd1;

  lives_frame_timer #(.W(8)) u_inv (
    .clk  (clk_25MHz),
    .rst  (rst),
    .load (inv_load),
    .dec  (inv_dec),
    .val  (8'(INVULN_FRAMES)),
    .cnt  (inv_cnt)
  );

  lives_frame_timer #(.W(4)) u_blk (
    .clk  (clk_25MHz),
    .rst  (rst),
    .load (blk_load),
    .dec  (blk_dec),
    .val  (4'(BLINK_FRAMES)),
    .cnt  (blk_cnt)
  );

  always_comb begin
    state_nx = state;
    lives_nx = lives;
    blink_nx = blink;
    me_nx    = tick ? lives : me_lifes;
    inv_load = 1'b0;
    inv_dec  = 1'b0;
    blk_load = 1'b0;
    blk_dec  = 1'b0;

    unique case (1'b1)
      (state == LS_IDLE) || (state == LS_OVER): begin
        if (bus.start) begin
          state_nx = LS_INVULN;
          lives_nx = 3'(START_LIVES);
          blink_nx = 1'b1;
          inv_load = 1'b1;
          blk_load = 1'b1;
        end
      end
      state == LS_PLAY: begin
        if (bus.hit) begin
          if (nl == 3'd0) begin
            // HUD drops to zero at once on game over
            state_nx = LS_OVER;
            lives_nx = 3'd0;
            me_nx    = 3'd0;
          end else begin
            state_nx = LS_INVULN;
            lives_nx = nl;
            blink_nx = 1'b1;
            inv_load = 1'b1;
            blk_load = 1'b1;
          end
        end else if (bonus_eff) begin
          lives_nx = sat;
        end
      end
      state == LS_INVULN: begin
        if (bonus_eff) begin
          lives_nx = sat;
        end
        if (tick) begin
          inv_dec = 1'b1;
          if (blk_cnt == 4'd1) begin
            blk_load = 1'b1;
            blink_nx = ~blink;
          end else begin
            blk_dec = 1'b1;
          end
          if (inv_cnt == 8'd1) begin
            state_nx = LS_PLAY;
            blink_nx = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state     <= LS_IDLE;
      lives     <= 3'd0;
      me_lifes  <= 3'd0;
      blink     <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      lives     <= lives_nx;
      me_lifes  <= me_nx;
      blink     <= blink_nx;
      invuln    <= (state_nx == LS_INVULN);
      game_over <= (state_nx == LS_OVER);
    end
  end

  assign bus.me_lifes  = me_lifes;
  assign bus.invuln    = invuln;
  assign bus.blink     = blink;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_lives_ctrl.sv
// tb_lives_ctrl: directed game sequences for lives_ctrl; expected
// outputs are queued with a due cycle and checked by a monitor.
module tb_lives_ctrl;

  typedef struct {
    string      name;
    int         due;
    logic [2:0] me;
    logic       inv;
    logic       blk;
    logic       go;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  exp_t sb[$];

  lives_ctrl_if bus ();

  lives_ctrl dut (
    .clk_25MHz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      nvec++;
      if ({bus.me_lifes, bus.invuln, bus.blink, bus.game_over}
          !== {e.me, e.inv, e.blk, e.go}) begin
        nfail++;
        $display("FAIL %s @%0d: got me=%0d inv=%b blk=%b go=%b, want me=%0d inv=%b blk=%b go=%b",
                 e.name, cyc, bus.me_lifes, bus.invuln, bus.blink,
                 bus.game_over, e.me, e.inv, e.blk, e.go);
      end
    end
  end

  task automatic chk(input string n, input logic [2:0] me,
                     input logic inv, input logic blk, input logic go);
    exp_t e;
    e.name = n;
    e.due  = cyc;
    e.me   = me;
    e.inv  = inv;
    e.blk  = blk;
    e.go   = go;
    sb.push_back(e);
  endtask

  task automatic drive(input logic s, input logic h,
                       input logic b, input logic tk);
    bus.start = s;
    bus.hit   = h;
    bus.bonus = b;
    bus.h_cnt = tk ? 10'd0 : 10'd5;
    bus.v_cnt = tk ? 10'd0 : 10'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.bonus = 1'b0;
    bus.h_cnt = 10'd5;
    bus.v_cnt = 10'd3;
  endtask

  // Ticks k=from..120 of an invulnerability window (2-cycle frames)
  task automatic window(input int from, input logic [2:0] me,
                        input bit full);
    for (int k = from; k <= 120; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      if (k == 120)
        chk("win_exit", me, 1'b0, 1'b0, 1'b0);
      else if (full)
        chk("blink", me, 1'b1, logic'(((k / 8) % 2) == 0), 1'b0);
      else if (k == 119)
        chk("win_end", me, 1'b1, logic'(((k / 8) % 2) == 0), 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.bonus = 1'b0;
    bus.h_cnt = 10'd5;
    bus.v_cnt = 10'd3;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle", 3'd0, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start", 3'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hud_pre_tick", 3'd0, 1'b1, 1'b1, 1'b0);
    window(1, 3'd3, 1'b1);

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit1", 3'd3, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hud_hold", 3'd3, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hud_upd", 3'd2, 1'b1, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit_ignored", 3'd2, 1'b1, 1'b1, 1'b0);
    window(6, 3'd2, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_in_play", 3'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit2", 3'd2, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hit2_hud", 3'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    window(2, 3'd1, 1'b0);

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over", 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("over_hit", 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("over_tick", 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart", 3'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_hud", 3'd3, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bonus_sat", 3'd3, 1'b1, 1'b1, 1'b0);
    window(2, 3'd3, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit_a", 3'd3, 1'b1, 1'b1, 1'b0);
    window(1, 3'd2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit_b", 3'd2, 1'b1, 1'b1, 1'b0);
    window(1, 3'd1, 1'b0);

    drive(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef LIVES_BONUS_EN
    chk("hit_bonus", 3'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst", 3'd1, 1'b1, 1'b1, 1'b0);
`else
    chk("hit_bonus", 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart2", 3'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst", 3'd3, 1'b1, 1'b1, 1'b0);
`endif

    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_tick", 3'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_after_rst", 3'd0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
